// File: rtl/stopwatch_time_counter.sv
// Stopwatch timekeeping: one-second prescaler feeding an MM:SS BCD digit chain.
// Optional lap snapshot registers are built only when STOPWATCH_LAP_EN is defined.
module stopwatch_time_counter #(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap,
  output logic [3:0] lap_min_tens,
  output logic [3:0] lap_min_ones,
  output logic [3:0] lap_sec_tens,
  output logic [3:0] lap_sec_ones,
  output logic       lap_valid,
`endif
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       tick,
  output logic       rollover
);

  localparam int               PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  function automatic logic [3:0] bcd_next(input logic [3:0] d, input logic [3:0] last);
    return (d == last) ? 4'd0 : d + 4'd1;
  endfunction

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [3:0]       sec_ones_q, sec_ones_d;
  logic [3:0]       sec_tens_q, sec_tens_d;
  logic [3:0]       min_ones_q, min_ones_d;
  logic [3:0]       min_tens_q, min_tens_d;
  logic             tick_q, tick_d;
  logic             rollover_q, rollover_d;
  logic             sec_elapsed;
  logic             so_carry, st_carry, mo_carry, mt_carry;

  always_comb begin
    sec_elapsed = enable && (pre_q == PRE_LAST);
    so_carry    = sec_elapsed && (sec_ones_q == 4'd9);
    st_carry    = so_carry && (sec_tens_q == 4'd5);
    mo_carry    = st_carry && (min_ones_q == 4'd9);
    mt_carry    = mo_carry && (min_tens_q == 4'd9);

    pre_d = pre_q;
    if (enable) pre_d = sec_elapsed ? '0 : pre_q + 1'b1;

    sec_ones_d = sec_elapsed ? bcd_next(sec_ones_q, 4'd9) : sec_ones_q;
    sec_tens_d = so_carry    ? bcd_next(sec_tens_q, 4'd5) : sec_tens_q;
    min_ones_d = st_carry    ? bcd_next(min_ones_q, 4'd9) : min_ones_q;
    min_tens_d = mo_carry    ? bcd_next(min_tens_q, 4'd9) : min_tens_q;
    tick_d     = sec_elapsed;
    rollover_d = mt_carry;

    // Clear overrides the count regardless of enable
    if (clear) begin
      pre_d      = '0;
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
      tick_d     = 1'b0;
      rollover_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q      <= '0;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      tick_q     <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      tick_q     <= tick_d;
      rollover_q <= rollover_d;
    end
  end

  assign sec_ones = sec_ones_q;
  assign sec_tens = sec_tens_q;
  assign min_ones = min_ones_q;
  assign min_tens = min_tens_q;
  assign tick     = tick_q;
  assign rollover = rollover_q;

`ifdef STOPWATCH_LAP_EN
  // Snapshot holds {min_tens, min_ones, sec_tens, sec_ones} as currently displayed
  logic [15:0] lap_time_q, lap_time_d;
  logic        lap_valid_q, lap_valid_d;

  always_comb begin
    lap_time_d  = lap_time_q;
    lap_valid_d = lap_valid_q;
    if (clear) begin
      lap_time_d  = 16'd0;
      lap_valid_d = 1'b0;
    end else if (lap) begin
      lap_time_d  = {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q};
      lap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lap_time_q  <= 16'd0;
      lap_valid_q <= 1'b0;
    end else begin
      lap_time_q  <= lap_time_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign lap_min_tens = lap_time_q[15:12];
  assign lap_min_ones = lap_time_q[11:8];
  assign lap_sec_tens = lap_time_q[7:4];
  assign lap_sec_ones = lap_time_q[3:0];
  assign lap_valid    = lap_valid_q;
`endif

endmodule
